// File: rtl/result_ram_reader.sv
// result_ram_reader
//   Walks the 64-entry signed result RAM through its synchronous read port,
//   streams each word on a valid/ready interface in linear index order and
//   accumulates a full-precision signed checksum of every delivered word.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   single-cycle run request (ignored while a run is active)
//   busy         out  run in progress
//   done         out  run complete, held until next accepted start or reset
//   ram_rd_en    out  result RAM read strobe
//   ram_rd_addr  out  result RAM read address (holds when ram_rd_en is low)
//   ram_rd_data  in   result RAM read data, valid one cycle after ram_rd_en
//   out_valid    out  stream word available
//   out_ready    in   downstream accepts word
//   out_data     out  stream word (signed)
//   out_index    out  linear index of out_data
//   out_last     out  high with the final index
//   checksum     out  signed running sum of transferred words
module result_ram_reader #(
  parameter int DATA_W    = 19,
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int TRANSPOSE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_rd_en,
  output logic [ADDR_W-1:0]        ram_rd_addr,
  input  logic [DATA_W-1:0]        ram_rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     out_last,
  output logic signed [DATA_W+5:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SUM_W = DATA_W + 6;
  localparam int HALF  = ADDR_W / 2;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Linear issue index to RAM address; transpose swaps the row/column halves.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] idx);
    logic [ADDR_W-1:0] res;
    if (TRANSPOSE != 0) begin
      res = {idx[HALF-1:0], idx[ADDR_W-1:HALF]};
    end else begin
      res = idx;
    end
    return res;
  endfunction

  function automatic logic signed [SUM_W-1:0] sign_ext(input logic [DATA_W-1:0] d);
    return {{(SUM_W - DATA_W){d[DATA_W-1]}}, d};
  endfunction

  state_t                    state_r, state_s;
  logic [CNT_W-1:0]          issued_r;
  logic                      inflight_r;
  logic [1:0]                fifo_count_r;
  logic                      fifo_wr_ptr_r, fifo_rd_ptr_r;
  logic [DATA_W-1:0]         fifo_mem_r [2];
  logic [ADDR_W-1:0]         addr_hold_r;
  logic [ADDR_W-1:0]         out_index_r;
  logic                      out_last_r;
  logic signed [SUM_W-1:0]   checksum_r;
  logic                      busy_r, done_r;

  logic                      rd_en_s;
  logic                      pop_s;
  logic                      valid_s;
  logic                      start_ok_s;
  logic [2:0]                occupancy_s;
  logic [DATA_W-1:0]         head_s;

  assign valid_s     = (fifo_count_r != 2'd0);
  assign pop_s       = valid_s && out_ready;
  assign head_s      = fifo_mem_r[fifo_rd_ptr_r];
  assign start_ok_s  = start && (state_r != ST_READ);
  // Words buffered plus the read landing next edge, after this cycle's pop.
  assign occupancy_s = {1'b0, fifo_count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and read-issue decision.
  always_comb begin
    state_s = state_r;
    rd_en_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_READ;
        end else begin
          state_s = state_r;
        end
      end
      ST_READ: begin
        rd_en_s = (issued_r < DEPTH_C) && (occupancy_s < 3'd2);
        if (pop_s && out_last_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_READ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Issue counter, FIFO bookkeeping, output counter, checksum and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_r      <= {CNT_W{1'b0}};
      inflight_r    <= 1'b0;
      fifo_count_r  <= 2'd0;
      fifo_wr_ptr_r <= 1'b0;
      fifo_rd_ptr_r <= 1'b0;
      addr_hold_r   <= {ADDR_W{1'b0}};
      out_index_r   <= {ADDR_W{1'b0}};
      out_last_r    <= 1'b0;
      checksum_r    <= {SUM_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else if (start_ok_s) begin
      issued_r      <= {CNT_W{1'b0}};
      inflight_r    <= 1'b0;
      fifo_count_r  <= 2'd0;
      fifo_wr_ptr_r <= 1'b0;
      fifo_rd_ptr_r <= 1'b0;
      out_index_r   <= {ADDR_W{1'b0}};
      out_last_r    <= 1'b0;
      checksum_r    <= {SUM_W{1'b0}};
      busy_r        <= 1'b1;
      done_r        <= 1'b0;
    end else begin
      inflight_r   <= rd_en_s;
      fifo_count_r <= fifo_count_r + {1'b0, inflight_r} - {1'b0, pop_s};
      if (rd_en_s) begin
        issued_r    <= issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
        addr_hold_r <= map_addr(issued_r[ADDR_W-1:0]);
      end
      if (inflight_r) begin
        fifo_wr_ptr_r <= ~fifo_wr_ptr_r;
      end
      if (pop_s) begin
        fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
        out_index_r   <= out_index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        out_last_r    <= (out_index_r == PRE_LAST);
        checksum_r    <= checksum_r + sign_ext(head_s);
        if (out_last_r) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  // FIFO storage: capture RAM data on the cycle after each read strobe.
  always_ff @(posedge clk) begin
    if (inflight_r && !reset) begin
      fifo_mem_r[fifo_wr_ptr_r] <= ram_rd_data;
    end
  end

  assign ram_rd_en   = rd_en_s;
  assign ram_rd_addr = rd_en_s ? map_addr(issued_r[ADDR_W-1:0]) : addr_hold_r;
  assign out_valid   = valid_s;
  assign out_data    = valid_s ? head_s : {DATA_W{1'b0}};
  assign out_index   = out_index_r;
  assign out_last    = out_last_r;
  assign checksum    = checksum_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule
